lsu_mem_path: RTL and testbench

- Synchronous load/store path from an LSU request to a local word memory and back.
- Request capture stage → single-port word memory → response register stage.
- Fully pipelined: accepts one request per cycle and returns one response per request, in order, at fixed latency.
- Sits between the core's load/store unit and a tightly-coupled data RAM.

---
 rtl/lsu_mem_path.sv | 102 ++++++++++
 tb/tb_lsu_mem_path.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_path.sv
// lsu_mem_path: three-stage LSU path (capture -> single-port word RAM -> response register).
// Define LSU_ADDR_CHECK_EN to flag and suppress requests with nonzero address bits above the word index.
module lsu_mem_path #(
    parameter int MEM_DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        lsu_req_i,
    input  logic        lsu_we_i,
    input  logic [3:0]  lsu_be_i,
    input  logic [31:0] lsu_addr_i,
    input  logic [31:0] lsu_wdata_i,
    output logic        lsu_rvalid_o,
    output logic [31:0] lsu_rdata_o
`ifdef LSU_ADDR_CHECK_EN
    ,
    output logic        lsu_err_o
`endif
);
    localparam int IDX_W = $clog2(MEM_DEPTH);

    logic [31:0]      mem [MEM_DEPTH];
    logic             s1_vld_q, s1_vld_d, s1_we_q, s1_we_d, s1_err_q, s1_err_d;
    logic [3:0]       s1_be_q, s1_be_d;
    logic [IDX_W-1:0] s1_idx_q, s1_idx_d;
    logic [31:0]      s1_wdata_q, s1_wdata_d;
    logic             s2_vld_q, s2_vld_d, s2_we_q, s2_we_d, s2_err_q, s2_err_d;
    logic [31:0]      rd_q, rd_d;
    logic             rvalid_q, rvalid_d, err_q, err_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             addr_err, mem_we;

`ifdef LSU_ADDR_CHECK_EN
    assign addr_err  = |lsu_addr_i[31:IDX_W];
    assign lsu_err_o = err_q;
`else
    logic unused_bits;
    assign addr_err    = 1'b0;
    assign unused_bits = ^{lsu_addr_i[31:IDX_W], err_q};
`endif

    assign lsu_rvalid_o = rvalid_q;
    assign lsu_rdata_o  = rdata_q;

    always_comb begin
        s1_vld_d   = lsu_req_i;
        s1_we_d    = lsu_req_i ? lsu_we_i : s1_we_q;
        s1_be_d    = lsu_req_i ? lsu_be_i : s1_be_q;
        s1_idx_d   = lsu_req_i ? lsu_addr_i[IDX_W-1:0] : s1_idx_q;
        s1_wdata_d = lsu_req_i ? lsu_wdata_i : s1_wdata_q;
        s1_err_d   = lsu_req_i ? addr_err : s1_err_q;
        // a store still in stage 1 when reset hits must not reach memory
        mem_we     = s1_vld_q & s1_we_q & ~s1_err_q & ~rst_i;
        rd_d       = (s1_vld_q && !s1_we_q) ? (s1_err_q ? 32'h0 : mem[s1_idx_q]) : rd_q;
        s2_vld_d   = s1_vld_q;
        s2_we_d    = s1_vld_q ? s1_we_q : s2_we_q;
        s2_err_d   = s1_vld_q & s1_err_q;
        rvalid_d   = s2_vld_q;
        err_d      = s2_vld_q & s2_err_q;
        rdata_d    = (s2_vld_q && !s2_we_q) ? rd_q : rdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (s1_be_q[b]) mem[s1_idx_q][8*b +: 8] <= s1_wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_vld_q   <= 1'b0;
            s1_we_q    <= 1'b0;
            s1_be_q    <= '0;
            s1_idx_q   <= '0;
            s1_wdata_q <= '0;
            s1_err_q   <= 1'b0;
            s2_vld_q   <= 1'b0;
            s2_we_q    <= 1'b0;
            s2_err_q   <= 1'b0;
            rd_q       <= '0;
            rvalid_q   <= 1'b0;
            err_q      <= 1'b0;
            rdata_q    <= '0;
        end else begin
            s1_vld_q   <= s1_vld_d;
            s1_we_q    <= s1_we_d;
            s1_be_q    <= s1_be_d;
            s1_idx_q   <= s1_idx_d;
            s1_wdata_q <= s1_wdata_d;
            s1_err_q   <= s1_err_d;
            s2_vld_q   <= s2_vld_d;
            s2_we_q    <= s2_we_d;
            s2_err_q   <= s2_err_d;
            rd_q       <= rd_d;
            rvalid_q   <= rvalid_d;
            err_q      <= err_d;
            rdata_q    <= rdata_d;
        end
    end
endmodule

// File: tb/tb_lsu_mem_path.sv
// tb_lsu_mem_path: directed vectors with hand-computed responses for lsu_mem_path.
module tb_lsu_mem_path;
    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        lsu_req_i = 1'b0;
    logic        lsu_we_i = 1'b0;
    logic [3:0]  lsu_be_i = 4'h0;
    logic [31:0] lsu_addr_i = '0;
    logic [31:0] lsu_wdata_i = '0;
    logic        lsu_rvalid_o;
    logic [31:0] lsu_rdata_o;
`ifdef LSU_ADDR_CHECK_EN
    logic        lsu_err_o;
`endif
    int checks = 0;
    int errors = 0;

    lsu_mem_path #(.MEM_DEPTH(256)) dut (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .lsu_req_i(lsu_req_i),
        .lsu_we_i(lsu_we_i),
        .lsu_be_i(lsu_be_i),
        .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i),
        .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o)
`ifdef LSU_ADDR_CHECK_EN
        ,
        .lsu_err_o(lsu_err_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // drive one request so it is sampled at the next edge; returns just after that edge
    task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr, input logic [31:0] wdata);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_be_i    = be;
        lsu_addr_i  = addr;
        lsu_wdata_i = wdata;
        step();
        lsu_req_i   = 1'b0;
        lsu_we_i    = 1'b0;
        lsu_be_i    = 4'h0;
        lsu_addr_i  = 32'hFFFF_FFFF;
        lsu_wdata_i = 32'hA5A5_A5A5;
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int i = 0; i < n; i++) begin
            step();
            p += int'(lsu_rvalid_o);
        end
    endtask

    initial begin
        int p;
        // 1: reset and idle
        step();
        step();
        rst_i = 1'b0;
        check("rst_rvalid", 32'(lsu_rvalid_o), 32'h0);
        check("rst_rdata", lsu_rdata_o, 32'h0);
`ifdef LSU_ADDR_CHECK_EN
        check("rst_err", 32'(lsu_err_o), 32'h0);
`endif
        count_pulses(10, p);
        check("idle_pulses", 32'(p), 32'h0);
        // 2: store then load, fixed 3-cycle latency
        issue(1'b1, 4'hF, 32'h1, 32'h0000_000F);
        step();
        check("st1_early", 32'(lsu_rvalid_o), 32'h0);
        step();
        check("st1_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("st1_rdata", lsu_rdata_o, 32'h0);
        issue(1'b0, 4'h0, 32'h1, 32'h0);
        step();
        step();
        check("ld1_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("ld1_rdata", lsu_rdata_o, 32'h0000_000F);
        step();
        check("ld1_drop", 32'(lsu_rvalid_o), 32'h0);
        check("ld1_hold", lsu_rdata_o, 32'h0000_000F);
        // 3: back-to-back store/load same index
        issue(1'b1, 4'hF, 32'h2, 32'hDEAD_BEEF);
        issue(1'b0, 4'h0, 32'h2, 32'h0);
        step();
        check("b2b_st_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("b2b_st_rdata", lsu_rdata_o, 32'h0000_000F);
        step();
        check("b2b_ld_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("b2b_ld_rdata", lsu_rdata_o, 32'hDEAD_BEEF);
        step();
        check("b2b_drop", 32'(lsu_rvalid_o), 32'h0);
        // 4: byte enables
        issue(1'b1, 4'hF, 32'h3, 32'h1122_3344);
        issue(1'b1, 4'h5, 32'h3, 32'hAABB_CCDD);
        issue(1'b0, 4'h0, 32'h3, 32'h0);
        step();
        step();
        check("be_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("be_rdata", lsu_rdata_o, 32'h11BB_33DD);
        issue(1'b1, 4'h0, 32'h3, 32'hFFFF_FFFF);
        issue(1'b0, 4'h0, 32'h3, 32'h0);
        step();
        check("be0_st_rvalid", 32'(lsu_rvalid_o), 32'h1);
        step();
        check("be0_rdata", lsu_rdata_o, 32'h11BB_33DD);
        // 5: reset discards a store still in stage 1
        issue(1'b1, 4'hF, 32'h4, 32'h0);
        step();
        step();
        step();
        issue(1'b1, 4'hF, 32'h4, 32'h55);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        count_pulses(4, p);
        check("abort_pulses", 32'(p), 32'h0);
        issue(1'b0, 4'h0, 32'h4, 32'h0);
        step();
        step();
        check("abort_ld_rvalid", 32'(lsu_rvalid_o), 32'h1);
        check("abort_ld_rdata", lsu_rdata_o, 32'h0);
        // 6: aliasing / address error
        issue(1'b1, 4'hF, 32'h101, 32'h77);
        issue(1'b0, 4'h0, 32'h1, 32'h0);
        issue(1'b0, 4'h0, 32'h101, 32'h0);
        check("alias_st_rvalid", 32'(lsu_rvalid_o), 32'h1);
`ifdef LSU_ADDR_CHECK_EN
        check("alias_st_err", 32'(lsu_err_o), 32'h1);
`endif
        step();
        check("alias_ld_rvalid", 32'(lsu_rvalid_o), 32'h1);
`ifdef LSU_ADDR_CHECK_EN
        check("alias_ld_rdata", lsu_rdata_o, 32'h0000_000F);
        check("alias_ld_err", 32'(lsu_err_o), 32'h0);
`else
        check("alias_ld_rdata", lsu_rdata_o, 32'h0000_0077);
`endif
        step();
        check("alias_ld2_rvalid", 32'(lsu_rvalid_o), 32'h1);
`ifdef LSU_ADDR_CHECK_EN
        check("alias_ld2_rdata", lsu_rdata_o, 32'h0);
        check("alias_ld2_err", 32'(lsu_err_o), 32'h1);
`else
        check("alias_ld2_rdata", lsu_rdata_o, 32'h0000_0077);
`endif
        step();
        check("end_rvalid", 32'(lsu_rvalid_o), 32'h0);
`ifdef LSU_ADDR_CHECK_EN
        check("end_err", 32'(lsu_err_o), 32'h0);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
